led_pattern_sched: RTL and testbench

Controller for the 4-bit LED strip. It arbitrates pattern commands from two requesters (A and B) using round-robin, then sequences the selected pattern (shift, bounce, blink or off) onto the LEDs. It owns the step-rate divider. Each accepted command runs for a fixed number of steps, after which the block returns to idle and accepts the next command. It sits between the command sources (key decoder, UART decoder) and the LED pins.

---
 rtl/led_pattern_sched_if.sv | 27 ++
 rtl/led_pattern_sched.sv | 159 +++++++++++++++
 tb/tb_led_pattern_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sched_if.sv
// ============================================================================
// Module      : led_pattern_sched_if
// Description : Two-requester pattern command handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_sched_if;
  logic       req_a_valid;
  logic [1:0] req_a_mode;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [1:0] req_b_mode;
  logic       req_b_ready;

  modport master (
    output req_a_valid, req_a_mode, req_b_valid, req_b_mode,
    input  req_a_ready, req_b_ready
  );

  modport slave (
    input  req_a_valid, req_a_mode, req_b_valid, req_b_mode,
    output req_a_ready, req_b_ready
  );
endinterface

`default_nettype wire

// File: rtl/led_pattern_sched.sv
// ============================================================================
// Module      : led_pattern_sched
// Description : Round-robin pattern command arbiter and LED pattern sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sched #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int RUN_STEPS = 8,
  parameter int LED_W     = 4
) (
  input  wire logic               sys_clk,
  input  wire logic               sys_rst,
  led_pattern_sched_if.slave      req,
  input  wire logic               stop,
  output logic [LED_W-1:0]        led,
  output logic                    busy,
  output logic [1:0]              cur_mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(RUN_STEPS + 1);

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(RUN_STEPS);
  localparam logic [LED_W-1:0] LED_ONE   = {{(LED_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              dir_q, dir_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [SW-1:0]     step_q, step_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [1:0]        mode_q, mode_d;

  logic              grant_a, grant_b, accept;
  logic [1:0]        sel_mode;
  logic [SW-1:0]     step_inc;
  logic [LED_W-1:0]  led_next, shl, shr;

  // On a tie the requester not granted last wins.
  assign grant_a  = req.req_a_valid & (~req.req_b_valid | last_b_q);
  assign grant_b  = req.req_b_valid & (~req.req_a_valid | ~last_b_q);
  assign req.req_a_ready = (state_q == S_IDLE) & ~sys_rst & grant_a;
  assign req.req_b_ready = (state_q == S_IDLE) & ~sys_rst & grant_b;
  assign accept   = (state_q == S_IDLE) & (grant_a | grant_b);
  assign sel_mode = grant_b ? req.req_b_mode : req.req_a_mode;

  assign step_inc = step_q + 1'b1;
  assign shl      = led_q << 1;
  assign shr      = led_q >> 1;

  always_comb begin
    led_next = led_q;
    case (mode_q)
      MODE_SHIFT:  led_next = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_BOUNCE: led_next = (dir_q == DIR_LEFT) ? shl : shr;
      MODE_BLINK:  led_next = ~led_q;
      default:     led_next = led_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    dir_d    = dir_q;
    tick_d   = tick_q;
    step_d   = step_q;
    led_d    = led_q;
    mode_d   = mode_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d   = sel_mode;
          last_b_d = grant_b;
          tick_d   = '0;
          step_d   = '0;
          case (sel_mode)
            MODE_SHIFT, MODE_BOUNCE: begin
              led_d   = LED_ONE;
              dir_d   = DIR_LEFT;
              state_d = S_RUN;
            end
            MODE_BLINK: begin
              led_d   = '1;
              state_d = S_RUN;
            end
            default: led_d = '0;
          endcase
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          led_d   = '0;
          tick_d  = '0;
          step_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          step_d = step_inc;
          led_d  = led_next;
          // Bounce reverses once the lit bit reaches either end.
          if (mode_q == MODE_BOUNCE) begin
            if (dir_q == DIR_LEFT && shl[LED_W-1]) dir_d = DIR_RIGHT;
            if (dir_q == DIR_RIGHT && shr[0])      dir_d = DIR_LEFT;
          end
          if (step_inc == STEP_LAST) state_d = S_IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      last_b_q <= 1'b1;
      dir_q    <= DIR_LEFT;
      tick_q   <= '0;
      step_q   <= '0;
      led_q    <= '0;
      mode_q   <= MODE_OFF;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      led_q    <= led_d;
      mode_q   <= mode_d;
    end
  end

  assign led      = led_q;
  assign busy     = (state_q == S_RUN);
  assign cur_mode = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sched.sv
// ============================================================================
// Module      : tb_led_pattern_sched
// Description : Self-checking bench for led_pattern_sched (TICK_DIV=4, RUN_STEPS=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sched;

  localparam int TD = 4;
  localparam int RS = 5;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          stop;
  logic [LW-1:0] led;
  logic          busy;
  logic [1:0]    cur_mode;

  int checks = 0;
  int errors = 0;

  bit         exp_last_b;
  logic [1:0] exp_mode;

  led_pattern_sched_if bus ();

  led_pattern_sched #(
    .TICK_DIV (TD),
    .RUN_STEPS(RS),
    .LED_W    (LW)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .req     (bus.slave),
    .stop    (stop),
    .led     (led),
    .busy    (busy),
    .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pattern after k advances, derived from the pattern definitions directly.
  function automatic logic [LW-1:0] pat(input logic [1:0] m, input int k);
    int p, pos;
    logic [LW-1:0] one;
    one = 1;
    case (m)
      2'd0: pat = one << (k % LW);
      2'd1: begin
        p   = k % (2 * LW - 2);
        pos = (p < LW) ? p : (2 * LW - 2 - p);
        pat = one << pos;
      end
      2'd2: pat = (k % 2 == 0) ? '1 : '0;
      default: pat = '0;
    endcase
  endfunction

  task automatic accept_run(input bit va, input bit vb, input logic [1:0] ma, input logic [1:0] mb,
                            input int stop_at, input bit keep_loser, input bit stop_idle,
                            input string tag);
    bit win_b;
    logic [1:0] m;
    bus.req_a_valid = va;
    bus.req_a_mode  = ma;
    bus.req_b_valid = vb;
    bus.req_b_mode  = mb;
    stop = stop_idle;
    win_b = (va && vb) ? !exp_last_b : vb;
    #1;
    chk({tag, ".rdyA"}, 8'(bus.req_a_ready), 8'(!win_b));
    chk({tag, ".rdyB"}, 8'(bus.req_b_ready), 8'(win_b));
    m = win_b ? mb : ma;
    step();
    exp_last_b = win_b;
    exp_mode   = m;
    stop = 1'b0;
    if (!keep_loser || win_b)  bus.req_b_valid = 1'b0;
    if (!keep_loser || !win_b) bus.req_a_valid = 1'b0;
    if (win_b && keep_loser) bus.req_b_valid = 1'b0;
    chk({tag, ".mode"}, 8'(cur_mode), 8'(m));
    if (m == 2'd3) begin
      chk({tag, ".offLed"}, 8'(led), 8'h0);
      chk({tag, ".offBusy"}, 8'(busy), 8'h0);
      return;
    end
    for (int n = 0; n <= RS * TD; n++) begin
      chk({tag, ".led"}, 8'(led), 8'(pat(m, n / TD)));
      chk({tag, ".busy"}, 8'(busy), 8'(n < RS * TD));
      if (n == RS * TD) break;
      chk({tag, ".runRdyA"}, 8'(bus.req_a_ready), 8'h0);
      chk({tag, ".runRdyB"}, 8'(bus.req_b_ready), 8'h0);
      if (n == stop_at) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk({tag, ".stopLed"}, 8'(led), 8'h0);
        chk({tag, ".stopBusy"}, 8'(busy), 8'h0);
        chk({tag, ".stopMode"}, 8'(cur_mode), 8'(m));
        return;
      end
      step();
    end
  endtask

  initial begin
    bit va, vb;
    clk = 1'b0;
    rst = 1'b1;
    stop = 1'b0;
    bus.req_a_valid = 1'b0;
    bus.req_a_mode  = 2'd0;
    bus.req_b_valid = 1'b0;
    bus.req_b_mode  = 2'd0;
    exp_last_b = 1'b1;
    exp_mode   = 2'd3;

    // Reset held for three cycles; ready must stay low even with a request.
    step();
    chk("rst.led", 8'(led), 8'h0);
    chk("rst.busy", 8'(busy), 8'h0);
    chk("rst.mode", 8'(cur_mode), 8'h3);
    bus.req_a_valid = 1'b1;
    #1;
    chk("rst.rdyA", 8'(bus.req_a_ready), 8'h0);
    bus.req_a_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("idle.rdyA", 8'(bus.req_a_ready), 8'h0);
    chk("idle.rdyB", 8'(bus.req_b_ready), 8'h0);

    accept_run(1, 0, 2'd0, 2'd0, -1, 0, 0, "shiftA");
    accept_run(0, 1, 2'd0, 2'd1, -1, 0, 0, "bounceB");
    accept_run(0, 1, 2'd0, 2'd2, -1, 0, 0, "blinkB");

    // Tie from reset: A first, B pending then granted, then A again.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_last_b = 1'b1;
    exp_mode   = 2'd3;
    chk("rr.rstMode", 8'(cur_mode), 8'h3);
    accept_run(1, 1, 2'd0, 2'd1, -1, 1, 0, "rr1");
    accept_run(0, 1, 2'd0, 2'd1, -1, 0, 0, "rr2");
    accept_run(1, 1, 2'd2, 2'd0, -1, 0, 0, "rr3");

    // Stop mid-run with B pending, then stop in IDLE alongside an accept.
    accept_run(0, 1, 2'd0, 2'd3, -1, 0, 0, "offB");
    accept_run(1, 1, 2'd0, 2'd1, 6, 1, 0, "stop6");
    accept_run(0, 1, 2'd0, 2'd1, -1, 0, 0, "pendB");
    accept_run(1, 0, 2'd0, 2'd0, -1, 0, 1, "stopIdle");
    accept_run(1, 0, 2'd3, 2'd0, -1, 0, 0, "offA");
    accept_run(1, 0, 2'd1, 2'd0, 3, 0, 0, "afterOff");

    // Asynchronous reset in the middle of a run with A still requesting.
    bus.req_a_valid = 1'b1;
    bus.req_a_mode  = 2'd0;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.led", 8'(led), 8'h0);
    chk("arst.busy", 8'(busy), 8'h0);
    chk("arst.mode", 8'(cur_mode), 8'h3);
    chk("arst.rdyA", 8'(bus.req_a_ready), 8'h0);
    step();
    rst = 1'b0;
    exp_last_b = 1'b1;
    exp_mode   = 2'd3;
    accept_run(1, 0, 2'd2, 2'd0, -1, 0, 0, "postRst");

    for (int i = 0; i < 10; i++) begin
      va = 1'($urandom % 2);
      vb = 1'($urandom % 2);
      if (!va && !vb) va = 1'b1;
      accept_run(va, vb, 2'($urandom % 4), 2'($urandom % 4),
                 ($urandom % 3 == 0) ? int'($urandom_range(0, RS * TD - 1)) : -1,
                 0, 1'($urandom % 2), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
